// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler
//   Shares the XADC DRP read port between two current-sense requesters
//   (motor A on VAUX6, motor B on VAUX14). One-cycle requests are latched
//   as pending bits, arbitrated round-robin, and serviced one at a time as a
//   single-cycle DEN read. The code in DO[15:4] is returned with a one-cycle
//   valid pulse, or a one-cycle timeout_err if DRDY never comes back.
// Ports
//   CLK100MHZ, rst      : clock, async active-high reset
//   req_a, req_b        : one-cycle read requests
//   data_a/valid_a      : last good code for A, update strobe
//   data_b/valid_b      : last good code for B, update strobe
//   timeout_err         : strobe when DRDY did not arrive in time
//   busy                : high whenever a read is in flight
//   drp_daddr, drp_den  : DRP address / enable to the XADC
//   drp_do, drp_drdy    : DRP read data / data-ready from the XADC
module xadc_drp_scheduler #(
  parameter logic [6:0] ADDR_A  = 7'h16,
  parameter logic [6:0] ADDR_B  = 7'h1E,
  parameter int         TIMEOUT = 64,
  parameter int         TO_W    = 7
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  output logic [11:0] data_a,
  output logic        valid_a,
  output logic [11:0] data_b,
  output logic        valid_b,
  output logic        timeout_err,
  output logic        busy,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic            pending_a, pending_b;
  logic            grant;       // 0 = A, 1 = B
  logic            last_grant;  // 0 = A, 1 = B
  logic [TO_W-1:0] timer;
  logic            next_grant;
  logic            done;
  logic            to_hit;

  // Both pending: alternate away from the last one served.
  assign next_grant = (pending_a && pending_b) ? ~last_grant : pending_b;

  // Timer counts cycles since DEN (0 during the DEN cycle); DRDY beats timeout.
  assign to_hit = (state == WAIT) && !drp_drdy && (timer == TO_W'(TIMEOUT - 1));
  assign done   = ((state == WAIT) && drp_drdy) || to_hit;

  assign busy = (state != IDLE);

  // A request in the finishing cycle re-arms the pending bit.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      pending_a <= 1'b0;
      pending_b <= 1'b0;
    end else begin
      if (req_a)                 pending_a <= 1'b1;
      else if (done && !grant)   pending_a <= 1'b0;
      if (req_b)                 pending_b <= 1'b1;
      else if (done && grant)    pending_b <= 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;  // A wins the first arbitration
      timer       <= '0;
      drp_daddr   <= '0;
      drp_den     <= 1'b0;
      data_a      <= '0;
      data_b      <= '0;
      valid_a     <= 1'b0;
      valid_b     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      drp_den     <= 1'b0;
      valid_a     <= 1'b0;
      valid_b     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pending_a || pending_b) begin
            grant     <= next_grant;
            drp_daddr <= next_grant ? ADDR_B : ADDR_A;
            drp_den   <= 1'b1;  // registered, so it is high during ISSUE
            timer     <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          last_grant <= grant;
          timer      <= timer + TO_W'(1);
          state      <= WAIT;
        end
        WAIT: begin
          if (drp_drdy) begin
            if (grant) begin
              data_b  <= drp_do[15:4];
              valid_b <= 1'b1;
            end else begin
              data_a  <= drp_do[15:4];
              valid_a <= 1'b1;
            end
            state <= IDLE;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Scoreboard bench for xadc_drp_scheduler. Stimulus plans each read from an
// abstract arbitration model (pending set + last served) and pushes the DRP
// response to give plus the expected completion event; a DRP responder and a
// separate output monitor pop and compare.
module tb_xadc_drp_scheduler;

  logic        clk, rst, req_a, req_b;
  logic [11:0] data_a, data_b;
  logic        valid_a, valid_b, timeout_err, busy;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic [15:0] drp_do;
  logic        drp_drdy;

  xadc_drp_scheduler dut (
    .CLK100MHZ(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .valid_a(valid_a), .data_b(data_b), .valid_b(valid_b),
    .timeout_err(timeout_err), .busy(busy), .drp_daddr(drp_daddr),
    .drp_den(drp_den), .drp_do(drp_do), .drp_drdy(drp_drdy)
  );

  // mode: 0 = answer after lat, 1 = never answer (timeout), 2 = aborted by reset
  typedef struct { logic [6:0] addr; logic [15:0] dout; int lat; int mode; int den_at; } rd_t;
  // kind: 0 = valid_a, 1 = valid_b, 2 = timeout_err
  typedef struct { int kind; logic [11:0] data; } ex_t;

  rd_t rd_q[$];
  ex_t ex_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, den_cnt = 0, den_cyc = 0, drdy_cyc = 0, resp_wait = 0;
  logic [15:0] resp_do = '0;
  bit   stray = 0, outstanding = 0;
  int   last_b = 1;
  logic [11:0] exp_da = '0, exp_db = '0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #500000; $display("FAIL watchdog: got running expected finished"); $fatal(1); end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Abstract model: record one read in service order.
  task automatic plan(input int b, input int mode, input int den_at, input logic [15:0] dout, input int lat);
    rd_t r; ex_t e;
    r.addr = (b != 0) ? 7'h1E : 7'h16;
    r.dout = dout; r.lat = lat; r.mode = mode; r.den_at = den_at;
    rd_q.push_back(r);
    if (mode == 0) begin e.kind = b; e.data = dout[15:4]; ex_q.push_back(e); end
    else if (mode == 1) begin e.kind = 2; e.data = '0; ex_q.push_back(e); end
    last_b = b;
  endtask

  function automatic int rlat();
    return int'($urandom_range(1, 8));
  endfunction

  // Pulse requests from idle; both at once -> the one not served last goes first.
  task automatic round(input bit ra, input bit rb, input int ma, input int mb, input bit dup);
    int fd;
    @(negedge clk);
    fd = cyc + 2;
    if (ra && rb) begin
      if (last_b != 0) begin
        plan(0, ma, fd, 16'($urandom), rlat()); plan(1, mb, -1, 16'($urandom), rlat());
      end else begin
        plan(1, mb, fd, 16'($urandom), rlat()); plan(0, ma, -1, 16'($urandom), rlat());
      end
    end else if (ra) plan(0, ma, fd, 16'($urandom), rlat());
    else if (rb)     plan(1, mb, fd, 16'($urandom), rlat());
    req_a = ra; req_b = rb;
    @(negedge clk);
    if (!dup) begin req_a = 0; req_b = 0; end
    @(negedge clk);
    req_a = 0; req_b = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rd_q.size() != 0 || ex_q.size() != 0 || busy || resp_wait != 0) && n < budget) begin
      @(negedge clk); #3; n++;
    end
    chk("drain_in_budget", 32'(n < budget), 1);
    if (n >= budget) begin rd_q.delete(); ex_q.delete(); resp_wait = 0; end
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset(input bit check);
    @(negedge clk);
    rst = 1; exp_da = '0; exp_db = '0; last_b = 1; outstanding = 0; resp_wait = 0;
    #1;
    if (check) begin
      chk("rst_data_a", 32'(data_a), 0);  chk("rst_data_b", 32'(data_b), 0);
      chk("rst_valid_a", 32'(valid_a), 0); chk("rst_valid_b", 32'(valid_b), 0);
      chk("rst_timeout", 32'(timeout_err), 0); chk("rst_busy", 32'(busy), 0);
      chk("rst_daddr", 32'(drp_daddr), 0); chk("rst_den", 32'(drp_den), 0);
    end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // DRP responder: checks each DEN against the planned read and answers it.
  initial begin
    rd_t r;
    drp_drdy = 0; drp_do = '0;
    forever begin
      @(negedge clk);
      drp_drdy = 0;
      if (stray) begin
        drp_drdy = 1; drp_do = 16'hFFFF; stray = 0;
      end else if (resp_wait > 0) begin
        resp_wait--;
        if (resp_wait == 0) begin drp_drdy = 1; drp_do = resp_do; drdy_cyc = cyc; end
      end
      if (drp_den && !rst) begin
        den_cnt++; den_cyc = cyc;
        chk("den_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          chk("den_daddr", 32'(drp_daddr), 32'(r.addr));
          if (r.den_at >= 0) chk("req_to_den_latency", 32'(cyc), 32'(r.den_at));
          if (r.mode == 0) begin resp_wait = r.lat; resp_do = r.dout; end
        end
      end
    end
  end

  // Output monitor: pops expected completions and tracks held data.
  initial begin
    ex_t e; int ak;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (drp_den) begin
          chk("den_while_outstanding", 32'(outstanding), 0);
          outstanding = 1;
        end
        if (valid_a || valid_b || timeout_err) begin
          ak = valid_a ? 0 : (valid_b ? 1 : 2);
          chk("single_event", 32'(int'(valid_a) + int'(valid_b) + int'(timeout_err)), 1);
          chk("busy_at_done", 32'(busy), 0);
          outstanding = 0;
          chk("event_expected", 32'(ex_q.size() != 0), 1);
          if (ex_q.size() != 0) begin
            e = ex_q.pop_front();
            chk("event_kind", 32'(ak), 32'(e.kind));
            if (ak == 2) chk("timeout_latency", 32'(cyc - den_cyc), 64);
            else begin
              chk("valid_latency", 32'(cyc - drdy_cyc), 1);
              if (ak == 0) exp_da = e.data; else exp_db = e.data;
            end
          end
        end
        chk("data_a", 32'(data_a), 32'(exp_da));
        chk("data_b", 32'(data_b), 32'(exp_db));
      end
    end
  end

  initial begin
    int start, n;
    rst = 1; req_a = 0; req_b = 0;
    #1;
    chk("por_den", 32'(drp_den), 0);
    chk("por_busy", 32'(busy), 0);
    apply_reset(1);

    // Single A read, DRDY 4 cycles after DEN with ABC5.
    @(negedge clk);
    plan(0, 0, cyc + 2, 16'hABC5, 4);
    req_a = 1; @(negedge clk); req_a = 0;
    drain(100);
    chk("t1_data_a", 32'(data_a), 32'h0ABC);

    // Simultaneous requests after reset: A then B, exactly two DENs.
    apply_reset(0);
    start = den_cnt;
    round(1, 1, 0, 0, 0);
    drain(100);
    chk("t2_den_count", 32'(den_cnt - start), 2);

    // Both held continuously: six alternating reads.
    @(negedge clk);
    start = den_cnt;
    plan((last_b != 0) ? 0 : 1, 0, cyc + 2, 16'($urandom), rlat());
    for (int i = 1; i < 6; i++) plan((last_b != 0) ? 0 : 1, 0, -1, 16'($urandom), rlat());
    req_a = 1; req_b = 1;
    n = 0;
    while (den_cnt < start + 5 && n < 200) begin @(negedge clk); #1; n++; end
    chk("t3_hold_reached", 32'(n < 200), 1);
    req_a = 0; req_b = 0;
    drain(200);
    chk("t3_den_count", 32'(den_cnt - start), 6);

    // B with no DRDY: timeout, then a normal B read.
    round(0, 1, 0, 1, 0);
    drain(200);
    round(0, 1, 0, 0, 0);
    drain(100);

    // Stray DRDY while idle must be ignored.
    stray = 1;
    repeat (6) @(negedge clk);
    chk("t5_idle_after_stray", 32'(busy), 0);

    // Randomized rounds, including merged repeat requests and timeouts.
    for (int i = 0; i < 24; i++) begin
      bit ra, rb; int ma, mb;
      ra = 0; rb = 0;
      case ($urandom_range(0, 2))
        0: ra = 1;
        1: rb = 1;
        default: begin ra = 1; rb = 1; end
      endcase
      ma = ($urandom_range(0, 7) == 0) ? 1 : 0;
      mb = ($urandom_range(0, 7) == 0) ? 1 : 0;
      round(ra, rb, ma, mb, 1'($urandom_range(0, 1)));
      drain(400);
    end

    // Reset two cycles into WAIT, DRDY a cycle later: read is dropped.
    @(negedge clk);
    plan(0, 2, cyc + 2, 16'h1234, 1);
    req_a = 1; @(negedge clk); req_a = 0;
    start = den_cnt; n = 0;
    while (den_cnt == start && n < 20) begin @(negedge clk); #1; n++; end
    chk("t6_den_seen", 32'(n < 20), 1);
    @(negedge clk); @(negedge clk);
    rst = 1; exp_da = '0; exp_db = '0; last_b = 1; outstanding = 0; resp_wait = 0;
    #1;
    chk("t6_data_a", 32'(data_a), 0); chk("t6_data_b", 32'(data_b), 0);
    chk("t6_valid_a", 32'(valid_a), 0); chk("t6_valid_b", 32'(valid_b), 0);
    chk("t6_timeout", 32'(timeout_err), 0); chk("t6_busy", 32'(busy), 0);
    chk("t6_daddr", 32'(drp_daddr), 0); chk("t6_den", 32'(drp_den), 0);
    stray = 1;
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_reissue", 32'(den_cnt - start), 1);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_queue_empty", 32'(ex_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
